// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the requester handshake, operand/result bus and the ALU-side
// signals of alu_arbiter.
//   master : requester/ALU side (drives req*, op*, alu_result)
//   slave  : arbiter side (drives gnt*, done*, busy, result_out, alu_data*,
//            alu_select)
// ----------------------------------------------------------------------------
interface alu_arbiter_if;
   localparam int unsigned DW = 8;
   localparam int unsigned SW = 3;

   // requester side
   logic          req0;
   logic          req1;
   logic [DW-1:0] op0_data1;
   logic [DW-1:0] op0_data2;
   logic [SW-1:0] op0_select;
   logic [DW-1:0] op1_data1;
   logic [DW-1:0] op1_data2;
   logic [SW-1:0] op1_select;
   logic          gnt0;
   logic          gnt1;
   logic          done0;
   logic          done1;
   logic          busy;
   logic [DW-1:0] result_out;

   // ALU side
   logic [DW-1:0] alu_data1;
   logic [DW-1:0] alu_data2;
   logic [SW-1:0] alu_select;
   logic [DW-1:0] alu_result;

   modport master (
      output req0, req1,
      output op0_data1, op0_data2, op0_select,
      output op1_data1, op1_data2, op1_select,
      input  gnt0, gnt1, done0, done1, busy, result_out,
      input  alu_data1, alu_data2, alu_select,
      output alu_result
   );

   modport slave (
      input  req0, req1,
      input  op0_data1, op0_data2, op0_select,
      input  op1_data1, op1_data2, op1_select,
      output gnt0, gnt1, done0, done1, busy, result_out,
      output alu_data1, alu_data2, alu_select,
      input  alu_result
   );
endinterface

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
// Shares one 8-bit ALU between two requesters. One operation at a time:
// grant latches the winner's operands onto the ALU inputs, the result is
// captured after SETTLE_CYCLES and returned with a one-cycle done pulse.
//
// Parameters
//   SETTLE_CYCLES : cycles the ALU inputs are held before capture (1..3)
// Ports
//   clk_i   : clock, rising edge
//   rst_n_i : synchronous active-low reset
//   arb_if  : alu_arbiter_if.slave (requests, grants, done, result, ALU bus)
// Configuration
//   ALU_RR_EN defined   : round-robin on ties (last-served pointer, resets
//                         to requester 1 so requester 0 wins the first tie)
//   ALU_RR_EN undefined : fixed priority, requester 0 wins ties
// ----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   alu_arbiter_if.slave  arb_if
);

   localparam int unsigned DW    = 8;
   localparam int unsigned SW    = 3;
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic           win_q, win_d;
   logic           gnt0_q, gnt0_d;
   logic           gnt1_q, gnt1_d;
   logic           done0_q, done0_d;
   logic           done1_q, done1_d;
   logic           busy_q, busy_d;
   logic [DW-1:0]  result_q, result_d;
   logic [DW-1:0]  alu_d1_q, alu_d1_d;
   logic [DW-1:0]  alu_d2_q, alu_d2_d;
   logic [SW-1:0]  alu_sel_q, alu_sel_d;
   logic           pick1_c;

`ifdef ALU_RR_EN
   logic           last_q, last_d;

   // On a tie the requester not served last wins.
   assign pick1_c = arb_if.req1 & (~arb_if.req0 | ~last_q);
`else
   // Requester 0 always wins a tie.
   assign pick1_c = arb_if.req1 & ~arb_if.req0;
`endif

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         win_q     <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         busy_q    <= 1'b0;
         result_q  <= '0;
         alu_d1_q  <= '0;
         alu_d2_q  <= '0;
         alu_sel_q <= '0;
`ifdef ALU_RR_EN
         last_q    <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         win_q     <= win_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         busy_q    <= busy_d;
         result_q  <= result_d;
         alu_d1_q  <= alu_d1_d;
         alu_d2_q  <= alu_d2_d;
         alu_sel_q <= alu_sel_d;
`ifdef ALU_RR_EN
         last_q    <= last_d;
`endif
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      win_d     = win_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      result_d  = result_q;
      alu_d1_d  = alu_d1_q;
      alu_d2_d  = alu_d2_q;
      alu_sel_d = alu_sel_q;
`ifdef ALU_RR_EN
      last_d    = last_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (arb_if.req0 || arb_if.req1) begin
               state_d = ST_EXEC;
               win_d   = pick1_c;
               cnt_d   = CNT_W'(SETTLE_CYCLES);
               gnt0_d  = ~pick1_c;
               gnt1_d  = pick1_c;
`ifdef ALU_RR_EN
               last_d  = pick1_c;
`endif
               if (pick1_c) begin
                  alu_d1_d  = arb_if.op1_data1;
                  alu_d2_d  = arb_if.op1_data2;
                  alu_sel_d = arb_if.op1_select;
               end else begin
                  alu_d1_d  = arb_if.op0_data1;
                  alu_d2_d  = arb_if.op0_data2;
                  alu_sel_d = arb_if.op0_select;
               end
            end
         end
         ST_EXEC: begin
            cnt_d = cnt_q - CNT_W'(1);
            // Last settle cycle: ALU output is stable, capture it.
            if (cnt_q == CNT_W'(1)) begin
               state_d  = ST_DONE;
               result_d = arb_if.alu_result;
               done0_d  = ~win_q;
               done1_d  = win_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign arb_if.gnt0       = gnt0_q;
   assign arb_if.gnt1       = gnt1_q;
   assign arb_if.done0      = done0_q;
   assign arb_if.done1      = done1_q;
   assign arb_if.busy       = busy_q;
   assign arb_if.result_out = result_q;
   assign arb_if.alu_data1  = alu_d1_q;
   assign arb_if.alu_data2  = alu_d2_q;
   assign arb_if.alu_select = alu_sel_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed steps followed by random traffic. A transaction-timeline model
// (grant edge, capture edge, first free edge) predicts every output each
// cycle; ALU behaviour is modelled with a plain function.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int unsigned SETTLE = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_arbiter_if bus ();

   alu_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .arb_if  (bus)
   );

   // Behavioural ALU: FORWARD(DATA2) / ADD / AND / OR, others return 0.
   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] s);
      case (s)
         3'd0:    return b;
         3'd1:    return a + b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         default: return 8'h00;
      endcase
   endfunction

   assign bus.alu_result = alu_fn(bus.alu_data1, bus.alu_data2, bus.alu_select);

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state, in units of clock edges.
   int         grant_cyc = -100;
   int         cap_cyc   = -100;
   int         free_cyc  = 0;
   logic       m_win     = 1'b0;
   logic       m_last    = 1'b1;
   logic [7:0] m_d1      = 8'h00;
   logic [7:0] m_d2      = 8'h00;
   logic [2:0] m_sel     = 3'd0;
   logic [7:0] m_res     = 8'h00;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic both;
      if (!rst_n) begin
         m_res = 8'h00; m_d1 = 8'h00; m_d2 = 8'h00; m_sel = 3'd0;
         m_last = 1'b1;
         grant_cyc = -100; cap_cyc = -100;
         free_cyc = cyc + 1;
      end else begin
         if (cyc == cap_cyc) m_res = alu_fn(m_d1, m_d2, m_sel);
         if (cyc >= free_cyc && (bus.req0 || bus.req1)) begin
            both = bus.req0 && bus.req1;
            if (both) begin
`ifdef ALU_RR_EN
               m_win = ~m_last;
`else
               m_win = 1'b0;
`endif
            end else begin
               m_win = bus.req1;
            end
            m_last = m_win;
            m_d1  = m_win ? bus.op1_data1  : bus.op0_data1;
            m_d2  = m_win ? bus.op1_data2  : bus.op0_data2;
            m_sel = m_win ? bus.op1_select : bus.op0_select;
            grant_cyc = cyc;
            cap_cyc   = cyc + int'(SETTLE);
            free_cyc  = cyc + int'(SETTLE) + 2;
         end
      end
   endtask

   task automatic check_all();
      logic g, d, b;
      g = (cyc == grant_cyc);
      d = (cyc == cap_cyc);
      b = (cyc >= grant_cyc) && (cyc <= cap_cyc);
      chk("gnt0",   8'(bus.gnt0),  8'(g && !m_win));
      chk("gnt1",   8'(bus.gnt1),  8'(g && m_win));
      chk("done0",  8'(bus.done0), 8'(d && !m_win));
      chk("done1",  8'(bus.done1), 8'(d && m_win));
      chk("busy",   8'(bus.busy),  8'(b));
      chk("result", bus.result_out, m_res);
      chk("alu_d1", bus.alu_data1,  m_d1);
      chk("alu_d2", bus.alu_data2,  m_d2);
      chk("alu_sel", 8'(bus.alu_select), 8'(m_sel));
   endtask

   // One clock: model sees the inputs present at the edge, outputs sampled
   // on the following falling edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic wait_done(input string tag, input logic exp_who, input logic [7:0] exp_res);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         tick();
         if (bus.done0 || bus.done1) seen = 1'b1;
      end
      chk({tag, "_seen"}, 8'(seen), 8'd1);
      chk({tag, "_who"},  8'(bus.done1), 8'(exp_who));
      chk({tag, "_res"},  bus.result_out, exp_res);
   endtask

   task automatic set_op0(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      bus.op0_data1 = a; bus.op0_data2 = b; bus.op0_select = s;
   endtask

   task automatic set_op1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      bus.op1_data1 = a; bus.op1_data2 = b; bus.op1_select = s;
   endtask

   initial begin
      int         ngnt;
      int         ndone;
      logic       order [4];
      logic       exp_o;
      logic [7:0] exp_r;

      rst_n = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      set_op0(8'h00, 8'h00, 3'd0);
      set_op1(8'h00, 8'h00, 3'd0);

      // Reset held two cycles with REQ0 high: nothing granted.
      bus.req0 = 1'b1;
      set_op0(8'h05, 8'h03, 3'b001);
      tick();
      tick();
      chk("rst_gnt0",   8'(bus.gnt0), 8'd0);
      chk("rst_busy",   8'(bus.busy), 8'd0);
      chk("rst_result", bus.result_out, 8'h00);
      chk("rst_alu_d1", bus.alu_data1, 8'h00);

      // Single ADD 05 + 03.
      rst_n = 1'b1;
      tick();
      chk("add_gnt0", 8'(bus.gnt0), 8'd1);
      chk("add_alu_sel", 8'(bus.alu_select), 8'd1);
      bus.req0 = 1'b0;
      wait_done("add", 1'b0, 8'h08);
      tick();
      chk("add_idle", 8'(bus.busy), 8'd0);

      // Tie with both requests held continuously.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_op0(8'hF0, 8'h3C, 3'b011);
      set_op1(8'hF0, 8'h3C, 3'b010);
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      ngnt = 0;
      ndone = 0;
      for (int i = 0; i < 4; i++) order[i] = 1'bx;
      for (int i = 0; i < 60 && ndone < 4; i++) begin
         tick();
         if (bus.gnt0 || bus.gnt1) begin
            if (ngnt < 4) order[ngnt] = bus.gnt1;
            ngnt++;
         end
         if (bus.done0 || bus.done1) begin
            exp_r = m_win ? 8'h30 : 8'hFC;
            chk("tie_res", bus.result_out, exp_r);
            ndone++;
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      chk("tie_ngnt", 8'(ngnt), 8'd4);
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_RR_EN
         exp_o = (i % 2) == 1;
`else
         exp_o = 1'b0;
`endif
         chk("tie_order", 8'(order[i]), 8'(exp_o));
      end
      tick();

      // Invalid select returns 00 but still completes.
      set_op1(8'h55, 8'hAA, 3'b111);
      bus.req1 = 1'b1;
      tick();
      chk("inv_gnt1", 8'(bus.gnt1), 8'd1);
      bus.req1 = 1'b0;
      wait_done("inv", 1'b1, 8'h00);
      tick();

      // Reset in the second EXEC cycle aborts the operation.
      set_op0(8'h10, 8'h20, 3'b001);
      bus.req0 = 1'b1;
      tick();
      chk("abort_gnt0", 8'(bus.gnt0), 8'd1);
      bus.req0 = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_result", bus.result_out, 8'h00);
      chk("abort_busy", 8'(bus.busy), 8'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("abort_nodone", 8'(bus.done0), 8'd0);
      end
      set_op1(8'h7E, 8'h7E, 3'b000);
      bus.req1 = 1'b1;
      tick();
      chk("fwd_gnt1", 8'(bus.gnt1), 8'd1);
      bus.req1 = 1'b0;
      wait_done("fwd", 1'b1, 8'h7E);
      tick();

      // Operand change after grant must not affect the result.
      set_op0(8'h11, 8'h11, 3'b000);
      bus.req0 = 1'b1;
      tick();
      chk("chg_gnt0", 8'(bus.gnt0), 8'd1);
      bus.req0 = 1'b0;
      bus.op0_data2 = 8'h22;
      wait_done("chg", 1'b0, 8'h11);
      tick();

      // Random traffic, occasional reset.
      for (int i = 0; i < 600; i++) begin
         rst_n    = ($urandom_range(0, 63) != 0);
         bus.req0 = ($urandom_range(0, 2) != 0);
         bus.req1 = ($urandom_range(0, 2) != 0);
         set_op0(8'($urandom), 8'($urandom), 3'($urandom));
         set_op1(8'($urandom), 8'($urandom), 3'($urandom));
         tick();
      end
      rst_n = 1'b1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("end_busy", 8'(bus.busy), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing arbiter that shares the single 8-bit ALU (FORWARD/ADD/AND/OR, 3-bit SELECT) between two requesters, e.g. the main datapath and a debug/test port. It accepts one operation at a time, drives the ALU operand and select inputs from registers, and waits a programmable settle time. It then captures the ALU result and returns it to the winning requester with a one-cycle completion pulse. It sits between the requesters and the ALU; the ALU itself is unchanged.

## Interface
- SETTLE_CYCLES, 1, number of cycles ALU inputs are held before RESULT is captured; legal 1..3.
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-low reset; sampled on rising CLK.
- REQ0, REQ1  input  1  operation request from requester 0 / 1; level, held until matching GNT.
- OP0_DATA1, OP0_DATA2 / OP1_DATA1, OP1_DATA2  input  8 each  operands of requester 0 / 1.
- OP0_SELECT / OP1_SELECT  input  3  ALU function code of requester 0 / 1.
- GNT0, GNT1  output  1  one-cycle pulse: request accepted, operands latched.
- DONE0, DONE1  output  1  one-cycle pulse: RESULT_OUT valid for that requester.
- RESULT_OUT  output  8  captured ALU result; holds until next capture.
- BUSY  output  1  high whenever state is not IDLE.
- ALU_DATA1, ALU_DATA2  output  8  registered operands to ALU DATA1/DATA2.
- ALU_SELECT  output  3  registered function code to ALU SELECT.
- ALU_RESULT  input  8  ALU RESULT.

## Operation
- States: IDLE, EXEC, DONE. Reset state IDLE.
- IDLE: no REQ -> stay. Any REQ -> choose winner, latch winner's DATA1/DATA2/SELECT into ALU_*, load settle counter with SETTLE_CYCLES, pulse winner's GNT, go EXEC.
- EXEC: counter decrements each cycle; on the edge where counter = 1, RESULT_OUT <= ALU_RESULT, go DONE.
- DONE: winner's DONE high for exactly this cycle; go IDLE unconditionally.
- ALU_* hold their values from grant until the next grant (not cleared in IDLE).
- Arbitration (ALU_RR_EN defined): round-robin; on a tie the requester not served last wins; last-served pointer resets to 1, so requester 0 wins the first tie.
- Only one GNT and one DONE ever high in any cycle; GNTx and DONEx never in the same cycle.
- SELECT 3'b100-3'b111 passed through unchanged; the ALU returns 8'h00, which is captured and returned normally with DONE.
- REQ still high in the cycle after DONE is a new request; REQ dropped before GNT withdraws it with no effect.
- Operands may change freely after GNT.
- Reset in any state: abort, return to IDLE, no GNT/DONE for the aborted operation.
- Reset values: GNT0=GNT1=0, DONE0=DONE1=0, BUSY=0, RESULT_OUT=8'h00, ALU_DATA1=ALU_DATA2=8'h00, ALU_SELECT=3'b000, pointer=1.

## Timing
- All outputs registered; no combinational path from any input to any output.
- REQ sampled high at edge E0 in IDLE -> GNT and new ALU_* visible after E0.
- Capture at edge E0+SETTLE_CYCLES.
- DONE and RESULT_OUT visible after that capture edge, for one cycle.
- IDLE re-entered at E0+SETTLE_CYCLES+1.
- Throughput: one operation per SETTLE_CYCLES+2 cycles; back-to-back requests are granted in the first IDLE cycle.
- CLK period × SETTLE_CYCLES must exceed ALU worst-case delay (ADD path ≈ 2-3 time units).

## Configuration
- ALU_RR_EN defined: round-robin arbitration as above.
- ALU_RR_EN undefined: fixed priority, requester 0 always wins ties. Pointer logic is absent; all other behaviour is identical.

## Test plan
- Reset: hold RESET=0 for 2 cycles with REQ0=1 -> no GNT; all outputs at reset values; BUSY=0.
- Single ADD, SETTLE_CYCLES=1: REQ0, OP0 = 8'h05 + 8'h03, SELECT 001 at E0 -> GNT0 after E0; RESULT_OUT=8'h08 and DONE0 after E1; IDLE at E2.
- Tie, ALU_RR_EN defined: REQ0 and REQ1 both held continuously -> grants alternate 0,1,0,1. Undefined -> grants 0,0,0. Per requester, OP1 AND 8'hF0 & 8'h3C returns 8'h30 and OP0 OR 8'hF0 | 8'h3C returns 8'hFC.
- Invalid select: SELECT=3'b111, DATA2=8'hAA -> DONE pulses, RESULT_OUT=8'h00.
- Reset mid-EXEC, SETTLE_CYCLES=3: assert RESET in the second EXEC cycle -> no DONE; RESULT_OUT=8'h00; the next REQ1 FORWARD 8'h7E completes normally with 8'h7E.
- Operand change after GNT: change OP0_DATA2 from 8'h11 to 8'h22 in the cycle after GNT0 with SELECT 000 -> RESULT_OUT=8'h11.
